// File: rtl/seg_pkg.sv
// seg_pkg: shared op codes, blank glyph, debounce states and hex-to-7-segment decoder
package seg_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADD  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_ARM,
        DB_PRESSED
    } db_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments g..a for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus debounce FSM emitting one pulse per press
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);
    import seg_pkg::*;

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          btn_s;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    assign btn_s       = sync_q[1];
    assign press_pulse = pulse_q;

    // Synchronise the raw button; data path needs no reset
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], btn_raw};
    end

    // Debounce FSM: ARM counts stable highs, PRESSED counts stable lows before re-arming
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                DB_IDLE: begin
                    cnt_q <= '0;
                    if (btn_s) state_q <= DB_ARM;
                end
                DB_ARM: begin
                    if (!btn_s) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= DB_PRESSED;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DB_PRESSED: begin
                    if (btn_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= DB_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_alu_display.sv
// seg_alu_display: button-latched W-bit ALU shown as hex on a multiplexed 7-segment display
// Optional SEG_OVF_DP_EN: drive digit 0 decimal point low on signed overflow.
module seg_alu_display #(
    parameter int W         = 4,
    parameter int DIGITS    = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int SCAN_DIV  = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [1:0]        op,
    input  logic              btn,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp
);
    import seg_pkg::*;

    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                load;
    logic [W:0]          ea, eb, r_d, r_q;
    logic                loaded_q;
    logic [DVW-1:0]      div_q;
    logic [IW-1:0]       idx_q;
    logic [4*DIGITS-1:0] rx;
    logic [3:0]          nib;
    logic                blank;
    logic [6:0]          seg_d, seg_q;
    logic [DIGITS-1:0]   an_d, an_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn),
        .press_pulse(load)
    );

    assign ea = {1'b0, a};
    assign eb = {1'b0, b};

    // W+1-bit result: zero-extended subtraction leaves the borrow in the top bit
    always_comb begin
        r_d = (op == OP_ADD) ? ea + eb :
              (op == OP_SUB) ? ea - eb :
              (op == OP_AND) ? (ea & eb) : ea;
    end

    // Latch the result only on the debounced press pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q      <= '0;
            loaded_q <= 1'b0;
        end else if (load) begin
            r_q      <= r_d;
            loaded_q <= 1'b1;
        end
    end

    // Digit divider and scan index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DVW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign rx = (4*DIGITS)'(r_q);
    assign nib = rx[{idx_q, 2'b00} +: 4];

    // Select the glyph and digit enable for the current scan slot
    always_comb begin
        blank = !loaded_q || (int'(idx_q) * 4 > W);
        seg_d = blank ? SEG_BLANK : hex_to_seg(nib);
        an_d  = ~(DIGITS'(1) << idx_q);
    end

    // Register the display pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

`ifdef SEG_OVF_DP_EN
    logic v_d, v_q, dp_q;

    // Signed overflow of the W-bit add/sub; pass and AND never overflow
    always_comb begin
        v_d = (op == OP_ADD) ? (a[W-1] == b[W-1]) && (r_d[W-1] != a[W-1]) :
              (op == OP_SUB) ? (a[W-1] != b[W-1]) && (r_d[W-1] != a[W-1]) : 1'b0;
    end

    // Overflow flag latched alongside the result
    always_ff @(posedge clk) begin
        if (!rst_n) v_q <= 1'b0;
        else if (load) v_q <= v_d;
    end

    // Decimal point lit on digit 0 while overflow is flagged
    always_ff @(posedge clk) begin
        if (!rst_n) dp_q <= 1'b1;
        else dp_q <= !((idx_q == '0) && v_q);
    end

    assign dp = dp_q;
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_alu_display.sv
// tb_seg_alu_display: table-driven scoreboard bench for seg_alu_display (honours SEG_OVF_DP_EN)
module tb_seg_alu_display;

    localparam int W = 4, DIGITS = 4, DB = 8, SD = 4;
`ifdef SEG_OVF_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, btn = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic [1:0] op = '0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks = 0, failures = 0;

    typedef struct {
        logic [3:0] a, b;
        logic [1:0] op;
        logic [4:0] r;
        logic       v;
    } vec_t;

    typedef struct {
        logic [4:0] r;
        logic       v;
        logic       loaded;
    } exp_t;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vec_t tbl [8];
    exp_t sb [$];

    always #5 clk = ~clk;

    seg_alu_display #(.W(W), .DIGITS(DIGITS), .DB_CYCLES(DB), .SCAN_DIV(SD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .op   (op),
        .btn  (btn),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] ta, input logic [3:0] tb_, input logic [1:0] top, input int hold, input int rel);
        a = ta; b = tb_; op = top;
        btn = 1'b1;
        cyc(hold);
        btn = 1'b0;
        cyc(rel);
    endtask

    task automatic check_display(input string name);
        exp_t       e;
        logic [3:0] seen, onehot;
        logic [15:0] rx;
        logic [6:0] es;
        logic       ed;
        int         k;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb actual=empty required=entry", name);
            return;
        end
        e    = sb.pop_front();
        rx   = {11'b0, e.r};
        seen = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            k = -1;
            for (int kk = 0; kk < DIGITS; kk++) begin
                onehot = ~(4'b1 << kk);
                if (an == onehot) k = kk;
            end
            chk({name, "_an_onehot"}, {31'b0, k >= 0}, 32'd1);
            if (k >= 0) begin
                seen[k] = 1'b1;
                es = (!e.loaded || 4 * k > W) ? 7'h7F : glyph[(rx >> (4 * k)) & 16'hF];
                ed = (k == 0 && DP_EN && e.v) ? 1'b0 : 1'b1;
                chk($sformatf("%s_seg_d%0d", name, k), {25'b0, seg}, {25'b0, es});
                chk($sformatf("%s_dp_d%0d", name, k), {31'b0, dp}, {31'b0, ed});
            end
        end
        chk({name, "_all_digits"}, {28'b0, seen}, 32'hF);
    endtask

    initial begin
        logic [3:0] exp_an;
        tbl[0] = '{4'h7, 4'h9, 2'b10, 5'h10, 1'b0};
        tbl[1] = '{4'h3, 4'h5, 2'b01, 5'h1E, 1'b0};
        tbl[2] = '{4'hC, 4'hA, 2'b11, 5'h08, 1'b0};
        tbl[3] = '{4'hD, 4'h2, 2'b00, 5'h0D, 1'b0};
        tbl[4] = '{4'h8, 4'h1, 2'b01, 5'h07, 1'b1};
        tbl[5] = '{4'hF, 4'hF, 2'b10, 5'h1E, 1'b0};
        tbl[6] = '{4'h0, 4'h1, 2'b01, 5'h1F, 1'b0};
        tbl[7] = '{4'h7, 4'h1, 2'b10, 5'h08, 1'b1};

        rst_n = 1'b0;
        cyc(3);
        chk("rst_seg", {25'b0, seg}, 32'h7F);
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_dp", {31'b0, dp}, 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            exp_an = ~(4'b1 << (i / 4));
            chk($sformatf("walk_an_%0d", i), {28'b0, an}, {28'b0, exp_an});
            chk($sformatf("walk_seg_%0d", i), {25'b0, seg}, 32'h7F);
        end

        for (int i = 0; i < 8; i++) begin
            sb.push_back('{tbl[i].r, tbl[i].v, 1'b1});
            press(tbl[i].a, tbl[i].b, tbl[i].op, 12, 14);
            a = ~tbl[i].a; b = ~tbl[i].b; op = ~tbl[i].op;
            check_display($sformatf("vec%0d", i));
        end

        a = 4'h5; b = 4'h5; op = 2'b10;
        repeat (4) begin
            btn = 1'b1; cyc(3);
            btn = 1'b0; cyc(3);
        end
        cyc(14);
        sb.push_back('{tbl[7].r, tbl[7].v, 1'b1});
        check_display("bounce");

        a = 4'h2; b = 4'h3; op = 2'b10;
        btn = 1'b1;
        cyc(30);
        a = 4'h9;
        cyc(70);
        btn = 1'b0;
        cyc(14);
        sb.push_back('{5'h05, 1'b0, 1'b1});
        check_display("hold");

        a = 4'h6; b = 4'h1; op = 2'b10;
        btn = 1'b1;
        cyc(5);
        rst_n = 1'b0;
        cyc(1);
        btn = 1'b0;
        cyc(2);
        chk("arm_rst_an", {28'b0, an}, 32'hF);
        chk("arm_rst_seg", {25'b0, seg}, 32'h7F);
        rst_n = 1'b1;
        cyc(20);
        sb.push_back('{5'h00, 1'b0, 1'b0});
        check_display("arm_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
